boot_loader: RTL and testbench

- Upstream of the single-cycle RISC-V core. Loads instruction memory from a byte stream (UART receiver or test host) before the core starts executing.
- Receives a framed image, assembles little-endian 32-bit words and writes them one at a time into instruction memory.
- Holds the core in reset until the whole image arrives and its checksum is verified.

---
 rtl/boot_loader_pkg.sv | 17 +
 rtl/boot_loader_if.sv | 29 ++
 rtl/boot_loader_word_assembler.sv | 39 +++
 rtl/boot_loader.sv | 131 +++++++++++++
 tb/tb_boot_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared definitions for the instruction-memory boot loader.
//   - FSM state encoding (3-bit)
//   - default frame start byte
package boot_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t LEN  = 3'd1;
  localparam state_t DATA = 3'd2;
  localparam state_t CSUM = 3'd3;
  localparam state_t DONE = 3'd4;
  localparam state_t ERR  = 3'd5;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input and instruction-memory write bus of the
// boot loader.
//   rx_valid/rx_data/rx_ready : byte stream, transfer on rx_valid && rx_ready
//   imem_we/imem_addr/imem_wdata : one-cycle word write into instruction memory
// Modports:
//   slave  : the loader (consumes bytes, issues memory writes)
//   master : the byte source / memory side
interface boot_loader_if #(
  parameter int ADDR_W = 6
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
//   clk       : clock
//   areset    : synchronous active-high reset
//   clear     : drop any partial word and restart at byte 0
//   byteStb   : a byte is presented on byteIn this cycle
//   byteIn    : byte data, byte k of a word lands in bits [8k+7:8k]
//   wordValid : high in the cycle the 4th byte of a word is presented
//   wordOut   : the completed word, valid while wordValid is high
module word_assembler (
  input  logic        clk,
  input  logic        areset,
  input  logic        clear,
  input  logic        byteStb,
  input  logic [7:0]  byteIn,
  output logic        wordValid,
  output logic [31:0] wordOut
);

  // Only the first three bytes need storage; the fourth is combined
  // directly so the word is available in the cycle it completes.
  logic [23:0] shiftReg;
  logic [1:0]  byteCnt;

  always_ff @(posedge clk) begin
    if (areset || clear) begin
      byteCnt  <= 2'd0;
      shiftReg <= 24'd0;
    end else if (byteStb) begin
      byteCnt  <= byteCnt + 2'd1;
      shiftReg <= {byteIn, shiftReg[23:8]};
    end
  end

  always_comb begin
    wordValid = byteStb && !clear && (byteCnt == 2'd3);
    wordOut   = {byteIn, shiftReg};
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a framed image (MAGIC, N, 4*N payload bytes, XOR
// checksum), writes it word by word into instruction memory and releases the
// core only after the checksum matches.
//   clk        : system clock, rising edge
//   areset     : synchronous active-high reset
//   bus        : boot_loader_if.slave (byte stream in, imem write bus out)
//   core_reset : high holds the core in reset
//   done       : image loaded and checksum good (sticky)
//   error      : frame rejected (sticky)
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter int         MAX_WORDS = 64,
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic         clk,
  input  logic         areset,
  boot_loader_if.slave bus,
  output logic         core_reset,
  output logic         done,
  output logic         error
);

  localparam logic [8:0] MAX_WORDS_9 = 9'(MAX_WORDS);

  state_t            state;
  state_t            nextState;
  logic              byteAcc;
  logic              dataStb;
  logic              asmClear;
  logic              wordValid;
  logic [31:0]       wordOut;
  logic [7:0]        lastIdx;
  logic [ADDR_W-1:0] wordIdx;
  logic [7:0]        xorAcc;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              readyDec;

  assign byteAcc  = bus.rx_valid && readyDec;
  assign dataStb  = byteAcc && (state == DATA);
  assign asmClear = (state != DATA);

  word_assembler u_asm (
    .clk       (clk),
    .areset    (areset),
    .clear     (asmClear),
    .byteStb   (dataStb),
    .byteIn    (bus.rx_data),
    .wordValid (wordValid),
    .wordOut   (wordOut)
  );

  // State register
  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (byteAcc && (bus.rx_data == MAGIC)) nextState = LEN;
      LEN: begin
        if (byteAcc) begin
          if ((bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAX_WORDS_9))
            nextState = ERR;
          else
            nextState = DATA;
        end
      end
      DATA: if (wordValid && (8'(wordIdx) == lastIdx)) nextState = CSUM;
      CSUM: begin
        if (byteAcc) nextState = (bus.rx_data == xorAcc) ? DONE : ERR;
      end
      default: nextState = state;
    endcase
  end

  // Output decode
  always_comb begin
    readyDec   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE, LEN, DATA, CSUM: readyDec = 1'b1;
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      ERR:     error = 1'b1;
      default: readyDec = 1'b0;
    endcase
  end

  // Frame bookkeeping and registered memory write port.
  // Write strobe lands the cycle after the word's 4th byte is accepted.
  always_ff @(posedge clk) begin
    if (areset) begin
      lastIdx   <= 8'd0;
      wordIdx   <= '0;
      xorAcc    <= 8'd0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWdata <= 32'd0;
    end else begin
      imemWe <= wordValid;
      if (wordValid) begin
        imemAddr  <= wordIdx;
        imemWdata <= wordOut;
        wordIdx   <= wordIdx + 1'b1;
      end
      if (byteAcc && (state == LEN)) begin
        lastIdx <= bus.rx_data - 8'd1;
        wordIdx <= '0;
        xorAcc  <= 8'd0;
      end
      if (dataStb) xorAcc <= xorAcc ^ bus.rx_data;
    end
  end

  assign bus.rx_ready   = readyDec;
  assign bus.imem_we    = imemWe;
  assign bus.imem_addr  = imemAddr;
  assign bus.imem_wdata = imemWdata;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  logic clk;
  logic areset;
  logic coreReset;
  logic done;
  logic error;

  boot_loader_if #(.ADDR_W(6)) bus ();

  boot_loader #(.ADDR_W(6), .MAX_WORDS(64), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .areset     (areset),
    .bus        (bus),
    .core_reset (coreReset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // Write monitor: logs every strobe seen on a rising edge.
  int          cyc;
  logic        prevWe;
  int          longStrobes;
  logic [5:0]  wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.imem_we === 1'b1) begin
      wrAddr.push_back(bus.imem_addr);
      wrData.push_back(bus.imem_wdata);
      wrCyc.push_back(cyc);
      if (prevWe === 1'b1) longStrobes = longStrobes + 1;
    end
    prevWe = bus.imem_we;
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        cr;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] img[64];

  function automatic vec_t mk(logic v, logic [7:0] d, logic rdy, logic we,
                              logic [5:0] addr, logic [31:0] wdata,
                              logic cr, logic dn, logic er);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
    r.wdata = wdata; r.cr = cr; r.dn = dn; r.er = er;
    return r;
  endfunction

  function automatic logic [42:0] obs();
    return {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
            coreReset, done, error};
  endfunction

  function automatic logic [42:0] expOf(vec_t e);
    return {e.rdy, e.we, e.addr, e.wdata, e.cr, e.dn, e.er};
  endfunction

  // {rx_ready, core_reset, done, error}
  function automatic logic [3:0] st();
    return {bus.rx_ready, coreReset, done, error};
  endfunction

  function automatic logic [5:0] wrA(int i);
    return (i < wrAddr.size()) ? wrAddr[i] : 6'bx;
  endfunction

  function automatic logic [31:0] wrD(int i);
    return (i < wrData.size()) ? wrData[i] : 32'bx;
  endfunction

  function automatic logic [7:0] calcCsum(int n);
    logic [7:0] c;
    c = 8'd0;
    for (int w = 0; w < n; w++)
      c = c ^ img[w][7:0] ^ img[w][15:8] ^ img[w][23:16] ^ img[w][31:24];
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed = passed + 1;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    longStrobes = 0;
  endtask

  // Hold reset for two edges, check the held values, release.
  task automatic doReset(input string tag);
    areset       = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rst_hold"}, 64'(obs()), 64'({1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    areset = 1'b0;
    clearLog();
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendWords(input int n, input int gap);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++)
        sendByte(8'(img[w] >> (8 * k)), gap);
  endtask

  task automatic sendFrame(input logic [7:0] n, input logic [7:0] csum, input int gap);
    sendByte(8'hA5, gap);
    sendByte(n, gap);
    sendWords(int'(n), gap);
    sendByte(csum, gap);
  endtask

  task automatic chkGoodWrites(input string tag);
    chk({tag, "_wr_cnt"}, 64'(wrAddr.size()), 64'd2);
    chk({tag, "_wr0"}, 64'({wrA(0), wrD(0)}), 64'({6'd0, 32'h00000013}));
    chk({tag, "_wr1"}, 64'({wrA(1), wrD(1)}), 64'({6'd1, 32'h00100093}));
    chk({tag, "_one_cycle_strobes"}, 64'(longStrobes), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0; cyc = 0; prevWe = 1'b0; longStrobes = 0;
    areset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Good frame, cycle by cycle. Checksum 13^93^10 = 90.
    vecs[0]  = mk(1, 8'hA5, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[1]  = mk(1, 8'h02, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[2]  = mk(1, 8'h13, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[3]  = mk(1, 8'h00, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[4]  = mk(1, 8'h00, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[5]  = mk(1, 8'h00, 1, 0, 6'd0, 32'h00000000, 1, 0, 0);
    vecs[6]  = mk(1, 8'h93, 1, 1, 6'd0, 32'h00000013, 1, 0, 0);
    vecs[7]  = mk(1, 8'h00, 1, 0, 6'd0, 32'h00000013, 1, 0, 0);
    vecs[8]  = mk(1, 8'h10, 1, 0, 6'd0, 32'h00000013, 1, 0, 0);
    vecs[9]  = mk(1, 8'h00, 1, 0, 6'd0, 32'h00000013, 1, 0, 0);
    vecs[10] = mk(1, 8'h90, 1, 1, 6'd1, 32'h00100093, 1, 0, 0);
    vecs[11] = mk(0, 8'h00, 0, 0, 6'd1, 32'h00100093, 0, 1, 0);
    vecs[12] = mk(1, 8'hA5, 0, 0, 6'd1, 32'h00100093, 0, 1, 0);
    vecs[13] = mk(0, 8'h00, 0, 0, 6'd1, 32'h00100093, 0, 1, 0);

    @(negedge clk);
    doReset("good");
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("good_vec%0d", i), 64'(obs()), 64'(expOf(vecs[i])));
      bus.rx_valid = vecs[i].v;
      bus.rx_data  = vecs[i].d;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chkGoodWrites("good");
    chk("good_strobe_spacing", 64'((wrCyc.size() == 2) ? (wrCyc[1] - wrCyc[0]) : -1), 64'd4);

    img[0] = 32'h00000013;
    img[1] = 32'h00100093;

    // Noise ahead of the start byte is dropped.
    doReset("noise");
    sendByte(8'h00, 0);
    sendByte(8'hFF, 0);
    sendByte(8'h5A, 0);
    chk("noise_still_idle", 64'(st()), 64'(4'b1100));
    sendFrame(8'd2, 8'h90, 0);
    chk("noise_done_release", 64'(st()), 64'(4'b0010));
    chkGoodWrites("noise");

    // Wrong checksum: writes happen, frame rejected, loader goes deaf.
    doReset("badcs");
    sendFrame(8'd2, 8'h91, 0);
    chk("badcs_error", 64'(st()), 64'(4'b0101));
    chkGoodWrites("badcs");
    sendFrame(8'd1, 8'h13, 0);
    chk("badcs_sticky", 64'(st()), 64'(4'b0101));
    chk("badcs_no_more_writes", 64'(wrAddr.size()), 64'd2);

    // Length of zero.
    doReset("len0");
    sendByte(8'hA5, 0);
    sendByte(8'h00, 0);
    chk("len0_error", 64'(st()), 64'(4'b0101));
    sendWords(2, 0);
    chk("len0_no_writes", 64'(wrAddr.size()), 64'd0);

    // Length one above the limit.
    doReset("len65");
    sendByte(8'hA5, 0);
    sendByte(8'd65, 0);
    chk("len65_error", 64'(st()), 64'(4'b0101));
    sendWords(2, 0);
    chk("len65_no_writes", 64'(wrAddr.size()), 64'd0);

    // Three idle cycles between every byte.
    doReset("gap");
    sendFrame(8'd2, 8'h90, 3);
    chk("gap_done_release", 64'(st()), 64'(4'b0010));
    chkGoodWrites("gap");
    chk("gap_strobe_spacing", 64'((wrCyc.size() == 2) ? (wrCyc[1] - wrCyc[0]) : -1), 64'd16);

    // Largest accepted image fills every address.
    for (int w = 0; w < 64; w++) img[w] = 32'h5A000000 + (w * 32'h00010203);
    doReset("max");
    sendFrame(8'd64, calcCsum(64), 0);
    chk("max_done_release", 64'(st()), 64'(4'b0010));
    chk("max_wr_cnt", 64'(wrAddr.size()), 64'd64);
    chk("max_last_write", 64'({wrA(63), wrD(63)}), 64'({6'd63, img[63]}));
    chk("max_first_write", 64'({wrA(0), wrD(0)}), 64'({6'd0, img[0]}));

    // Reset in the middle of the payload, then a fresh one-word frame.
    img[0] = 32'h00000013;
    img[1] = 32'h00100093;
    doReset("mid");
    sendByte(8'hA5, 0);
    sendByte(8'h02, 0);
    for (int b = 0; b < 6; b++) sendByte(8'(img[b / 4] >> (8 * (b % 4))), 0);
    doReset("mid2");
    chk("mid_first_cycle_after_reset", 64'(obs()),
        64'({1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    img[0] = 32'hDEADBEEF;
    sendFrame(8'd1, 8'h22, 0);
    chk("mid_done_release", 64'(st()), 64'(4'b0010));
    chk("mid_wr_cnt", 64'(wrAddr.size()), 64'd1);
    chk("mid_wr0", 64'({wrA(0), wrD(0)}), 64'({6'd0, 32'hDEADBEEF}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
